// File: rtl/radix_8_ntt_pipe.sv
// Pipelined 8-point NTT/INTT butterfly over Z_Q: twiddle multiply, three radix-2 layers, natural-order output.
// Optional macro RADIX8_NTT_INV_SCALE_EN adds a fifth stage that scales inverse beats by 8^-1 mod Q.
module radix_8_ntt_pipe #(
    parameter int              N        = 17,
    parameter longint unsigned Q        = 65537,
    parameter longint unsigned W8       = 16,
    parameter longint unsigned W8INV    = 61441,
    parameter longint unsigned EIGHTINV = 57345
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           mode,
    input  logic [8*N-1:0] a_flat,
    input  logic [7*N-1:0] tf_flat,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_mode,
    output logic [8*N-1:0] A_flat
);

    localparam longint unsigned FW1 = W8 % Q;
    localparam longint unsigned FW2 = (FW1 * FW1) % Q;
    localparam longint unsigned FW3 = (FW2 * FW1) % Q;
    localparam longint unsigned IW1 = W8INV % Q;
    localparam longint unsigned IW2 = (IW1 * IW1) % Q;
    localparam longint unsigned IW3 = (IW2 * IW1) % Q;

    localparam logic [N-1:0] QN     = N'(Q);
    localparam logic [N-1:0] C_FW1  = N'(FW1);
    localparam logic [N-1:0] C_FW2  = N'(FW2);
    localparam logic [N-1:0] C_FW3  = N'(FW3);
    localparam logic [N-1:0] C_IW1  = N'(IW1);
    localparam logic [N-1:0] C_IW2  = N'(IW2);
    localparam logic [N-1:0] C_IW3  = N'(IW3);

    function automatic logic [N-1:0] mod_add(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, QN}) s = s - {1'b0, QN};
        return s[N-1:0];
    endfunction

    function automatic logic [N-1:0] mod_sub(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [N:0] s;
        if (x >= y) s = {1'b0, x} - {1'b0, y};
        else        s = {1'b0, x} + {1'b0, QN} - {1'b0, y};
        return s[N-1:0];
    endfunction

    function automatic logic [N-1:0] mod_mul(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2*N-1:0] p;
        p = {{N{1'b0}}, x} * {{N{1'b0}}, y};
        p = p % {{N{1'b0}}, QN};
        return p[N-1:0];
    endfunction

    logic w_advance;

    logic [N-1:0] w_s1_next [8];
    logic [N-1:0] w_s2_next [8];
    logic [N-1:0] w_s3_next [8];
    logic [N-1:0] w_s4_next [8];
    logic [N-1:0] w_out_next [8];
    logic         w_out_valid_next;
    logic         w_out_mode_next;

    logic [N-1:0] r_s1 [8];
    logic [N-1:0] r_s2 [8];
    logic [N-1:0] r_s3 [8];
    logic [N-1:0] r_out [8];
    logic         r_s1_valid, r_s2_valid, r_s3_valid, r_out_valid;
    logic         r_s1_mode,  r_s2_mode,  r_s3_mode,  r_out_mode;

    // Reset forces advance so the block reports ready for the whole reset cycle.
    assign w_advance = !rst_n || !r_out_valid || out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_out_valid;
    assign out_mode  = r_out_mode;

    // S1: tf0 is implicitly 1, so a0 passes straight through.
    assign w_s1_next[0] = a_flat[0 +: N];
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_s1
            assign w_s1_next[gi] = mod_mul(a_flat[gi*N +: N], tf_flat[(gi-1)*N +: N]);
        end
    endgenerate

    // S2: w^4 = -1, so pairs (j, j+4) split into even-k sums and odd-k differences.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_s2
            assign w_s2_next[gi]     = mod_add(r_s1[gi], r_s1[gi+4]);
            assign w_s2_next[gi + 4] = mod_sub(r_s1[gi], r_s1[gi+4]);
        end
    endgenerate

    // S3: slots 0..3 hold c0..c3 (even outputs), 4..7 hold d0..d3 (odd outputs).
    logic [N-1:0] w_s3_w2;
    logic [N-1:0] w_s3_t2;
    logic [N-1:0] w_s3_t3;

    assign w_s3_w2 = r_s2_mode ? C_IW2 : C_FW2;
    assign w_s3_t2 = mod_mul(r_s2[6], w_s3_w2);
    assign w_s3_t3 = mod_mul(r_s2[7], w_s3_w2);

    assign w_s3_next[0] = mod_add(r_s2[0], r_s2[2]);
    assign w_s3_next[1] = mod_sub(r_s2[0], r_s2[2]);
    assign w_s3_next[2] = mod_add(r_s2[1], r_s2[3]);
    assign w_s3_next[3] = mod_sub(r_s2[1], r_s2[3]);
    assign w_s3_next[4] = mod_add(r_s2[4], w_s3_t2);
    assign w_s3_next[5] = mod_sub(r_s2[4], w_s3_t2);
    assign w_s3_next[6] = mod_add(r_s2[5], w_s3_t3);
    assign w_s3_next[7] = mod_sub(r_s2[5], w_s3_t3);

    // S4: final butterflies land directly in natural order A0..A7.
    logic [N-1:0] w_s4_w1, w_s4_w2, w_s4_w3;
    logic [N-1:0] w_s4_u, w_s4_v, w_s4_x;

    assign w_s4_w1 = r_s3_mode ? C_IW1 : C_FW1;
    assign w_s4_w2 = r_s3_mode ? C_IW2 : C_FW2;
    assign w_s4_w3 = r_s3_mode ? C_IW3 : C_FW3;
    assign w_s4_u  = mod_mul(r_s3[3], w_s4_w2);
    assign w_s4_v  = mod_mul(r_s3[6], w_s4_w1);
    assign w_s4_x  = mod_mul(r_s3[7], w_s4_w3);

    assign w_s4_next[0] = mod_add(r_s3[0], r_s3[2]);
    assign w_s4_next[4] = mod_sub(r_s3[0], r_s3[2]);
    assign w_s4_next[2] = mod_add(r_s3[1], w_s4_u);
    assign w_s4_next[6] = mod_sub(r_s3[1], w_s4_u);
    assign w_s4_next[1] = mod_add(r_s3[4], w_s4_v);
    assign w_s4_next[5] = mod_sub(r_s3[4], w_s4_v);
    assign w_s4_next[3] = mod_add(r_s3[5], w_s4_x);
    assign w_s4_next[7] = mod_sub(r_s3[5], w_s4_x);

`ifdef RADIX8_NTT_INV_SCALE_EN
    localparam logic [N-1:0] C_EINV = N'(EIGHTINV % Q);

    logic [N-1:0] r_s4 [8];
    logic         r_s4_valid;
    logic         r_s4_mode;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s4_valid <= 1'b0;
        end else if (w_advance) begin
            r_s4_valid <= r_s3_valid;
            r_s4_mode  <= r_s3_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (w_advance) begin
            for (int k = 0; k < 8; k++) r_s4[k] <= w_s4_next[k];
        end
    end

    // S5: only inverse beats are scaled; forward beats pass with the same latency.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_s5
            assign w_out_next[gi] = r_s4_mode ? mod_mul(r_s4[gi], C_EINV) : r_s4[gi];
        end
    endgenerate
    assign w_out_valid_next = r_s4_valid;
    assign w_out_mode_next  = r_s4_mode;
`else
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_out
            assign w_out_next[gi] = w_s4_next[gi];
        end
    endgenerate
    assign w_out_valid_next = r_s3_valid;
    assign w_out_mode_next  = r_s3_mode;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s3_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_mode  <= 1'b0;
            for (int k = 0; k < 8; k++) r_out[k] <= '0;
        end else if (w_advance) begin
            r_s1_valid  <= in_valid;
            r_s1_mode   <= mode;
            r_s2_valid  <= r_s1_valid;
            r_s2_mode   <= r_s1_mode;
            r_s3_valid  <= r_s2_valid;
            r_s3_mode   <= r_s2_mode;
            r_out_valid <= w_out_valid_next;
            r_out_mode  <= w_out_mode_next;
            for (int k = 0; k < 8; k++) r_out[k] <= w_out_next[k];
        end
    end

    // Inner data registers carry no reset; their valids gate everything downstream.
    always_ff @(posedge clk) begin
        if (w_advance) begin
            for (int k = 0; k < 8; k++) begin
                r_s1[k] <= w_s1_next[k];
                r_s2[k] <= w_s2_next[k];
                r_s3[k] <= w_s3_next[k];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pack
            assign A_flat[gi*N +: N] = r_out[gi];
        end
    endgenerate

endmodule

// File: doc/radix_8_ntt_pipe.md
RADIX_8_NTT_PIPE -- requirements
Module: radix_8_ntt_pipe

Interface
REQ-001 Parameter N, default 17: coefficient width in bits.
REQ-002 Parameter Q, default 65537: modulus; Q < 2^N.
REQ-003 Parameter W8, default 16: primitive 8th root of unity mod Q.
REQ-004 Parameter W8INV, default 61441: W8^-1 mod Q.
REQ-005 Parameter EIGHTINV, default 57345: 8^-1 mod Q.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 in_valid  input  1  input beat valid.
REQ-009 in_ready  output  1  block accepts beat this cycle.
REQ-010 mode  input  1  0 = forward (root W8), 1 = inverse (root W8INV); sampled with beat.
REQ-011 a_flat  input  8*N  coefficients a0..a7, a_j at bits [j*N +: N].
REQ-012 tf_flat  input  7*N  twiddles tf1..tf7, tf_j at bits [(j-1)*N +: N]; tf0 is implicitly 1.
REQ-013 out_valid  output  1  result beat valid.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_mode  output  1  mode carried with the beat.
REQ-016 A_flat  output  8*N  results A0..A7, A_k at bits [k*N +: N], natural order.

Function
REQ-017 A_k SHALL equal sum over j=0..7 of (a_j * tf_j * w^(j*k)) mod Q, w = W8 (mode 0) or W8INV (mode 1); every output SHALL lie in [0, Q).
REQ-018 Inputs SHALL be in [0, Q); results for out-of-range inputs are unspecified.
REQ-019 Pipeline of 4 register stages: S1 twiddle modular multiply; S2 radix-2 layer (pairs j, j+4); S3 radix-2 layer with w^2-class constants; S4 final layer with w, w^3 constants and output reorder.
REQ-020 Latency SHALL be exactly 4 cycles from accepted beat to out_valid when never stalled; throughput 1 beat/cycle.
REQ-021 Global advance = !out_valid || out_ready; in_ready SHALL equal advance; all stage registers (data, valid, mode) load only when advance = 1.
REQ-022 A beat is accepted iff in_valid && in_ready; a result is consumed iff out_valid && out_ready.
REQ-023 While out_valid && !out_ready, A_flat, out_mode and out_valid SHALL hold stable; no beat lost, duplicated or reordered.
REQ-024 Bubbles (in_valid = 0 while advancing) SHALL propagate as invalid stages; out_valid low for the corresponding cycle.
REQ-025 mode MAY change on every beat; each beat is processed with its own sampled mode.
REQ-026 Additions/subtractions SHALL be reduced mod Q with one conditional correction; multiplications SHALL use full 2N-bit products reduced mod Q.

Reset
REQ-027 rst_n low at a clock edge SHALL clear all stage valids; out_valid = 0, out_mode = 0, A_flat = 0 the following cycle.
REQ-028 Reset mid-stream SHALL discard all in-flight beats; in_ready = 1 during and after reset.
REQ-029 Data registers other than output register need not be reset.

Configuration
REQ-030 Macro RADIX8_NTT_INV_SCALE_EN defined: for mode = 1 beats, an extra stage S5 multiplies every A_k by EIGHTINV mod Q; latency 5 cycles for all beats (mode 0 passes S5 unscaled).
REQ-031 Macro undefined: no S5, latency 4, inverse results unscaled (8x the true inverse).

Verification
REQ-032 a = (1,0,0,0,0,0,0,0), all tf = 1, mode 0 -> all A_k = 1 after 4 cycles.
REQ-033 a all 1, tf all 1, mode 0 -> A0 = 8, A1..A7 = 0.
REQ-034 a = (0,1,0,...,0), tf all 1, mode 0 -> A = (1,16,256,4096,65536,65521,65281,61441).
REQ-035 Random 20-beat stream with out_ready low cycles 3-5 -> outputs match model in order, held stable while stalled, in_ready low while stalled and full.
REQ-036 Forward result fed back with mode 1, tf all 1, macro defined -> original a recovered; macro undefined -> 8*a mod Q.
REQ-037 rst_n low for 1 cycle with 3 beats in flight -> out_valid 0 next cycle, no stale beat ever emerges.
